// File: rtl/selector_sequencer.sv
// selector_sequencer: drives the combinational selector datapath.
// On an accepted start it latches operands/opcode/mask, walks the enabled
// select slots in ascending order, holds each one-hot select for
// SETTLE_CYCLES+1 cycles, captures s0 per slot and pulses done at the end.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    request / cancel a sequence
//   slot_mask       enabled slots (bit i -> select = 1<<i)
//   a_in, b_in      operands, latched on accept
//   opcode_in       opcode, latched on accept
//   s0              selector result
//   select          one-hot select (0 when not scanning)
//   A, B, opCodeA   latched operands/opcode to the selector
//   busy, done      sequence in progress / end-of-sequence pulse
//   result_valid    per-slot capture flags for the current sequence
//   result          packed captures, byte i = slot i
module selector_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  slot_mask,
    input  logic [3:0]  a_in,
    input  logic [3:0]  b_in,
    input  logic [2:0]  opcode_in,
    input  logic [7:0]  s0,
    output logic [3:0]  select,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [2:0]  opCodeA,
    output logic        busy,
    output logic        done,
    output logic [3:0]  result_valid,
    output logic [31:0] result
);

    localparam int unsigned SLOTS = 4;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SLOTS-1:0]   select_q, select_d;
    logic [SLOTS-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         a_q, a_d;
    logic [3:0]         b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SLOTS-1:0]   rv_q, rv_d;
    logic [8*SLOTS-1:0] result_q, result_d;

    // Isolate the lowest set bit: gives ascending slot order.
    function automatic logic [SLOTS-1:0] lowest(input logic [SLOTS-1:0] m);
        return m & (~m + SLOTS'(1));
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            select_q <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rv_q     <= rv_d;
            result_q <= result_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rv_d     = rv_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                // abort is ignored here; start alone decides.
                if (start) begin
                    a_d    = a_in;
                    b_d    = b_in;
                    op_d   = opcode_in;
                    pend_d = slot_mask;
                    rv_d   = '0;
                    if (slot_mask != '0) begin
                        state_d  = ST_SCAN;
                        select_d = lowest(slot_mask);
                        cnt_d    = SETTLE_LD;
                        busy_d   = 1'b1;
                    end else begin
                        // Empty mask: straight to the done pulse, busy never shows.
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    // Abort beats a same-edge capture.
                    state_d  = ST_IDLE;
                    select_d = '0;
                    pend_d   = '0;
                    busy_d   = 1'b0;
                end else if (cnt_q == '0) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (select_q[i]) begin
                            result_d[8*i +: 8] = s0;
                            rv_d[i]            = 1'b1;
                        end
                    end
                    pend_d = pend_q & ~select_q;
                    if (pend_d != '0) begin
                        select_d = lowest(pend_d);
                        cnt_d    = SETTLE_LD;
                    end else begin
                        state_d  = ST_FINISH;
                        select_d = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                select_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign select       = select_q;
    assign A            = a_q;
    assign B            = b_q;
    assign opCodeA      = op_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign result       = result_q;

endmodule

// File: tb/tb_selector_sequencer.sv
// Directed bench for selector_sequencer; two instances (SETTLE 1 and 0)
// each fed by a stub selector model s0 = {select, B}.
module tb_selector_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [3:0]  slot_mask, a_in, b_in;
    logic [2:0]  opcode_in;

    logic [7:0]  s0, s0_z;
    logic [3:0]  select, A, B, select_z, A_z, B_z;
    logic [2:0]  opCodeA, op_z;
    logic        busy, done, busy_z, done_z;
    logic [3:0]  result_valid, rv_z;
    logic [31:0] result, result_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign s0   = {select, B};
    assign s0_z = {select_z, B_z};

    selector_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .slot_mask(slot_mask), .a_in(a_in), .b_in(b_in), .opcode_in(opcode_in),
        .s0(s0), .select(select), .A(A), .B(B), .opCodeA(opCodeA),
        .busy(busy), .done(done), .result_valid(result_valid), .result(result)
    );

    selector_sequencer #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .slot_mask(slot_mask), .a_in(a_in), .b_in(b_in), .opcode_in(opcode_in),
        .s0(s0_z), .select(select_z), .A(A_z), .B(B_z), .opCodeA(op_z),
        .busy(busy_z), .done(done_z), .result_valid(rv_z), .result(result_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        slot_mask = '0; a_in = '0; b_in = '0; opcode_in = '0;
        #1;
        total++;
        if ({select, A, B, opCodeA, busy, done, result_valid, result} !== 53'd0) begin
            bad++;
            $display("FAIL reset_state got sel=%b busy=%b done=%b rv=%b res=%h exp all zero",
                     select, busy, done, result_valid, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_sweep();
        logic [3:0] exp_sel;
        slot_mask = 4'b1111; a_in = 4'd1; b_in = 4'd2; opcode_in = 3'd7; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        total++;
        if (select !== 4'b0001 || busy !== 1'b1 || A !== 4'd1 || B !== 4'd2 || opCodeA !== 3'd7) begin
            bad++;
            $display("FAIL sweep_accept got sel=%b busy=%b A=%h B=%h op=%h exp 0001 1 1 2 7",
                     select, busy, A, B, opCodeA);
        end
        for (int k = 1; k < 8; k++) begin
            if (k == 1) a_in = 4'd9;
            tick();
            exp_sel = 4'(1 << (k / 2));
            total++;
            if (select !== exp_sel || done !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL sweep_step%0d got sel=%b done=%b busy=%b exp sel=%b done=0 busy=1",
                         k, select, done, busy, exp_sel);
            end
        end
        total++;
        if (A !== 4'd1) begin
            bad++;
            $display("FAIL sweep_a_hold got A=%h exp 1", A);
        end
        tick(); // edge 8
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || select !== 4'b0000) begin
            bad++;
            $display("FAIL sweep_done got done=%b busy=%b sel=%b exp 1 0 0000", done, busy, select);
        end
        total++;
        if (result !== 32'h82422212 || result_valid !== 4'b1111) begin
            bad++;
            $display("FAIL sweep_result got res=%h rv=%b exp 82422212 1111", result, result_valid);
        end
        tick(); // edge 9
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL sweep_done_once got done=%b exp 0", done);
        end
    endtask

    task automatic test_sparse();
        slot_mask = 4'b1010; a_in = 4'd3; b_in = 4'hF; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        total++;
        if (select !== 4'b0010) begin
            bad++;
            $display("FAIL sparse_first got sel=%b exp 0010", select);
        end
        tick(); // edge 1
        start = 1'b1; a_in = 4'hC; slot_mask = 4'b0001;
        tick(); // edge 2: slot 1 captured
        start = 1'b0;
        total++;
        if (select !== 4'b1000 || A !== 4'd3 || result_valid !== 4'b0010) begin
            bad++;
            $display("FAIL sparse_second got sel=%b A=%h rv=%b exp 1000 3 0010", select, A, result_valid);
        end
        tick(); // edge 3
        total++;
        if (done !== 1'b0 || select !== 4'b1000) begin
            bad++;
            $display("FAIL sparse_hold got done=%b sel=%b exp 0 1000", done, select);
        end
        tick(); // edge 4
        start = 1'b1; // during FINISH: must be ignored
        total++;
        if (done !== 1'b1 || result_valid !== 4'b1010 || result !== 32'h8F422F12) begin
            bad++;
            $display("FAIL sparse_done got done=%b rv=%b res=%h exp 1 1010 8f422f12",
                     done, result_valid, result);
        end
        tick(); // edge 5: back to IDLE, start in FINISH not taken
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || select !== 4'b0000 || done !== 1'b0) begin
            bad++;
            $display("FAIL finish_start_ignored got busy=%b sel=%b done=%b exp 0 0000 0",
                     busy, select, done);
        end
    endtask

    task automatic test_empty();
        slot_mask = 4'b0000; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || select !== 4'b0000 || result_valid !== 4'b0000) begin
            bad++;
            $display("FAIL empty_done got done=%b busy=%b sel=%b rv=%b exp 1 0 0000 0000",
                     done, busy, select, result_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (done !== 1'b0 || select !== 4'b0000 || result !== 32'h8F422F12) begin
                bad++;
                $display("FAIL empty_after%0d got done=%b sel=%b res=%h exp 0 0000 8f422f12",
                         k, done, select, result);
            end
        end
    endtask

    task automatic test_abort();
        slot_mask = 4'b1111; b_in = 4'd2; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        repeat (3) tick(); // edges 1..3
        abort = 1'b1;
        tick(); // edge 4: slot 1 would be captured
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || select !== 4'b0000 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_state got busy=%b sel=%b done=%b exp 0 0000 0", busy, select, done);
        end
        total++;
        if (result_valid !== 4'b0001 || result !== 32'h8F422F12) begin
            bad++;
            $display("FAIL abort_result got rv=%b res=%h exp 0001 8f422f12", result_valid, result);
        end
        repeat (3) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_done got done=%b busy=%b exp 0 0", done, busy);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        slot_mask = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick(); // captured slot 0 at edge 2
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (select !== 4'b0000 || busy !== 1'b0 || result_valid !== 4'b0000 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid got sel=%b busy=%b rv=%b res=%h exp 0000 0 0000 0",
                     select, busy, result_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || select !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release got busy=%b sel=%b exp 0 0000", busy, select);
        end
    endtask

    task automatic test_settle0();
        logic [3:0] exp_sel;
        slot_mask = 4'b1111; b_in = 4'd2; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            exp_sel = 4'(1 << k);
            total++;
            if (select_z !== exp_sel || done_z !== 1'b0 || busy_z !== 1'b1) begin
                bad++;
                $display("FAIL settle0_step%0d got sel=%b done=%b busy=%b exp sel=%b 0 1",
                         k, select_z, done_z, busy_z, exp_sel);
            end
        end
        tick(); // edge 4
        total++;
        if (done_z !== 1'b1 || select_z !== 4'b0000 || rv_z !== 4'b1111 || result_z !== 32'h82422212) begin
            bad++;
            $display("FAIL settle0_done got done=%b sel=%b rv=%b res=%h exp 1 0000 1111 82422212",
                     done_z, select_z, rv_z, result_z);
        end
        tick();
        total++;
        if (done_z !== 1'b0) begin
            bad++;
            $display("FAIL settle0_done_once got done=%b exp 0", done_z);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_sparse();
        test_empty();
        test_abort();
        test_reset_mid_scan();
        test_settle0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
